minisrc_ctrl_seq: RTL and testbench
===================================

Name: minisrc_ctrl_seq

Overview:
- Parametrised multi-cycle control sequencer for the MiniSRC datapath.
- Decodes the IR opcode and drives every register enable, mux select, ALU control and RF write strobe of the datapath.
- Adds two things the fixed 5-cycle sequence lacks: ready-qualified instruction/data memory wait states, and a configurable multi-cycle MUL/DIV execute.
- Counts retired instructions.

Parameters:
- MULDIV_CYCLES, 4: execute cycles for mul/div (>=1).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- iClk  in  1  clock, rising edge.
- nRst  in  1  reset, asynchronous, active-low.
- iOpcode  in  5  IR[31:27].
- iZero  in  1  ALU zero flag.
- iIMemReady  in  1  instruction memory data valid.
- iDMemReady  in  1  data memory access complete.
- oIMemReq  out  1  instruction fetch request.
- oMemRead, oMemWrite  out  1 each  data memory strobes.
- oIrEn, oRaEn, oRbEn, oRz0En, oRz1En, oRmEn, oRyEn, oPcEn, oPcTempEn  out  1 each  register enables.
- oRfWrite  out  1  register file write.
- oMbSel  out  1  0=RB, 1=immediate.
- oMincSel  out  1  0=+4, 1=branch offset.
- oMpcSel  out  1  0=RA, 1=PC adder.
- oMySel  out  2  0=RZ0, 1=RZ1, 2=mem, 3=return addr.
- oMcSel  out  2  0=IR ra field, 2=link reg.
- oAluCtrl  out  4  0000 add, 0001 sub, 0010 or, 0011 and, 0100 div, 0101 mul.
- oHalted  out  1  core halted.
- oIllegal  out  1  one-cycle pulse on undefined opcode.
- oRetired  out  CNT_W  retired instruction count.

Behaviour:
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, mul 01111, div 10000, brzr 10010, jr 10011, jal 10100, nop 11010, halt 11011.
- Any other opcode is illegal. It executes as nop, and oIllegal pulses in DECODE.
- States: FETCH, DECODE, EXEC, EXWAIT, MEM, RY, WB, HALT.
- Reset (nRst low, at any time including mid-access):
  - State goes to FETCH, the wait counter and oRetired go to 0, and every output is 0.
  - Outputs are gated to 0 while nRst is low.
  - oIMemReq rises in the first cycle after release.
- All unlisted outputs are 0 in each state. oAluCtrl defaults to 0000.
- FETCH:
  - oIMemReq=1.
  - Hold while iIMemReady=0.
  - In the ready cycle: oIrEn=1, oPcTempEn=1 (captures the old PC), oPcEn=1, oMpcSel=1, oMincSel=0. Go to DECODE.
- DECODE:
  - oRaEn=1, oRbEn=1.
  - halt -> HALT; nop/illegal -> FETCH (counts as retired); else -> EXEC.
- EXEC, per opcode:
  - add/sub/and/or: oAluCtrl per op, oMbSel=0, oRz0En=1 -> RY.
  - addi/ldi: add, oMbSel=1, oRz0En=1 -> RY.
  - ld/st: add, oMbSel=1, oRz0En=1 (address). st also sets oRmEn=1. -> MEM.
  - mul/div: hold oAluCtrl.
    - If MULDIV_CYCLES==1: oRz0En=oRz1En=1 -> RY.
    - Else: load the counter with MULDIV_CYCLES-2 -> EXWAIT.
  - brzr: oAluCtrl=sub. If iZero=1: oPcEn=1, oMpcSel=1, oMincSel=1. -> FETCH (retired).
  - jr: oPcEn=1, oMpcSel=0 -> FETCH (retired).
  - jal: oPcEn=1, oMpcSel=0 -> RY.
- EXWAIT:
  - oAluCtrl held.
  - Counter decrements each cycle.
  - In the cycle the counter==0: oRz0En=oRz1En=1 -> RY.
- MEM:
  - ld: oMemRead=1; st: oMemWrite=1. Held until iDMemReady=1.
  - On ready, ld -> RY; st -> FETCH (retired).
- RY:
  - oRyEn=1.
  - oMySel: 2 for ld, 3 for jal, 0 otherwise. -> WB.
- WB:
  - oRfWrite=1.
  - oMcSel: 2 for jal, 0 otherwise.
  - Retired. -> FETCH.
- Minimum latency from FETCH entry to next FETCH, with zero wait states:
  - ALU ops: 5 cycles.
  - ld: 6 cycles.
  - st, branch, jr: 4 or 3 cycles (st 4, branch/jr 3).
  - mul/div: 4 + MULDIV_CYCLES cycles.
- oRetired increments by 1 on each retire event and wraps at 2^CNT_W-1 -> 0.
- HALT: oHalted=1, all other outputs 0. The only exit is reset.

Test Plan:
- Reset mid-FETCH with iIMemReady=0 -> all outputs 0 asynchronously; after release oIMemReq=1 and oRetired=0.
- add (00011), ready always 1 -> exactly 5 cycles.
  - oIrEn in cycle 1, oRz0En with oAluCtrl=0000 in cycle 3, oRfWrite in cycle 5.
  - oRetired goes 0->1.
- ld (00000) with iDMemReady low 3 cycles -> oMemRead held 4 cycles; oRyEn with oMySel=2; oRfWrite; total 9 cycles.
- mul (01111), MULDIV_CYCLES=4 -> oAluCtrl=0101 for 4 cycles; oRz0En=oRz1En=1 only on the 4th; instruction takes 8 cycles.
- brzr with iZero=1 -> oPcEn with oMincSel=1 in EXEC, 3 cycles. With iZero=0 -> no EXEC oPcEn, 3 cycles. oRetired increments by 2 over the pair.
- Opcode 11111 then halt (11011) -> oIllegal pulses for exactly 1 cycle and the illegal op retires; after halt, oHalted=1 and oIMemReq stays 0 for 20 cycles.

Source files
------------

// File: rtl/minisrc_ctrl_seq.sv
// MiniSRC multi-cycle control sequencer.
// Decodes the IR opcode and sequences the datapath through
// fetch/decode/execute/memory/write-back.
// Instruction and data memory accesses stall on their ready signals.
// MUL/DIV execute runs for a configurable number of cycles.
// Retired instructions are counted.
module minisrc_ctrl_seq #(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             iClk,
  input  logic             nRst,
  input  logic [4:0]       iOpcode,
  input  logic             iZero,
  input  logic             iIMemReady,
  input  logic             iDMemReady,
  output logic             oIMemReq,
  output logic             oMemRead,
  output logic             oMemWrite,
  output logic             oIrEn,
  output logic             oRaEn,
  output logic             oRbEn,
  output logic             oRz0En,
  output logic             oRz1En,
  output logic             oRmEn,
  output logic             oRyEn,
  output logic             oPcEn,
  output logic             oPcTempEn,
  output logic             oRfWrite,
  output logic             oMbSel,
  output logic             oMincSel,
  output logic             oMpcSel,
  output logic [1:0]       oMySel,
  output logic [1:0]       oMcSel,
  output logic [3:0]       oAluCtrl,
  output logic             oHalted,
  output logic             oIllegal,
  output logic [CNT_W-1:0] oRetired
);

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpBrzr = 5'b10010;
  localparam logic [4:0] OpJr   = 5'b10011;
  localparam logic [4:0] OpJal  = 5'b10100;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluOr  = 4'b0010;
  localparam logic [3:0] AluAnd = 4'b0011;
  localparam logic [3:0] AluDiv = 4'b0100;
  localparam logic [3:0] AluMul = 4'b0101;

  // Wait counter holds MULDIV_CYCLES-2 at most; keep at least one bit.
  localparam int unsigned WaitW = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES - 1) : 1;
  localparam logic [WaitW-1:0] WaitLoad =
      (MULDIV_CYCLES >= 2) ? WaitW'(MULDIV_CYCLES - 2) : '0;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StExWait, StMem, StRy, StWb, StHalt
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Opcode class flags.
  logic is_ld, is_ldi, is_st, is_add, is_sub, is_and, is_or, is_addi;
  logic is_mul, is_div, is_brzr, is_jr, is_jal, is_nop, is_halt, is_legal;

  // Raw (ungated) control outputs.
  logic       imem_req, mem_read, mem_write, ir_en, ra_en, rb_en, rz0_en, rz1_en;
  logic       rm_en, ry_en, pc_en, pc_temp_en, rf_write, mb_sel, minc_sel, mpc_sel;
  logic       halted, illegal, retire;
  logic [1:0] my_sel, mc_sel;
  logic [3:0] alu_ctrl, alu_rr, alu_md;

  // Opcode decode.
  always_comb begin
    is_ld    = (iOpcode == OpLd);
    is_ldi   = (iOpcode == OpLdi);
    is_st    = (iOpcode == OpSt);
    is_add   = (iOpcode == OpAdd);
    is_sub   = (iOpcode == OpSub);
    is_and   = (iOpcode == OpAnd);
    is_or    = (iOpcode == OpOr);
    is_addi  = (iOpcode == OpAddi);
    is_mul   = (iOpcode == OpMul);
    is_div   = (iOpcode == OpDiv);
    is_brzr  = (iOpcode == OpBrzr);
    is_jr    = (iOpcode == OpJr);
    is_jal   = (iOpcode == OpJal);
    is_nop   = (iOpcode == OpNop);
    is_halt  = (iOpcode == OpHalt);
    is_legal = is_ld | is_ldi | is_st | is_add | is_sub | is_and | is_or | is_addi |
               is_mul | is_div | is_brzr | is_jr | is_jal | is_nop | is_halt;
    alu_rr   = AluAdd;
    if (is_sub) alu_rr = AluSub;
    if (is_and) alu_rr = AluAnd;
    if (is_or)  alu_rr = AluOr;
    alu_md   = is_mul ? AluMul : AluDiv;
  end

  // Next-state, wait counter, retire event and raw control outputs.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_en      = 1'b0;
    ra_en      = 1'b0;
    rb_en      = 1'b0;
    rz0_en     = 1'b0;
    rz1_en     = 1'b0;
    rm_en      = 1'b0;
    ry_en      = 1'b0;
    pc_en      = 1'b0;
    pc_temp_en = 1'b0;
    rf_write   = 1'b0;
    mb_sel     = 1'b0;
    minc_sel   = 1'b0;
    mpc_sel    = 1'b0;
    my_sel     = 2'd0;
    mc_sel     = 2'd0;
    alu_ctrl   = AluAdd;
    halted     = 1'b0;
    illegal    = 1'b0;

    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (iIMemReady) begin
          ir_en      = 1'b1;
          pc_temp_en = 1'b1;
          pc_en      = 1'b1;
          mpc_sel    = 1'b1;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        ra_en = 1'b1;
        rb_en = 1'b1;
        if (is_halt) begin
          state_d = StHalt;
        end else if (is_nop || !is_legal) begin
          illegal = !is_legal;
          retire  = 1'b1;
          state_d = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_add || is_sub || is_and || is_or) begin
          alu_ctrl = alu_rr;
          rz0_en   = 1'b1;
          state_d  = StRy;
        end else if (is_addi || is_ldi) begin
          mb_sel  = 1'b1;
          rz0_en  = 1'b1;
          state_d = StRy;
        end else if (is_ld || is_st) begin
          mb_sel  = 1'b1;
          rz0_en  = 1'b1;
          rm_en   = is_st;
          state_d = StMem;
        end else if (is_mul || is_div) begin
          alu_ctrl = alu_md;
          if (MULDIV_CYCLES == 32'd1) begin
            rz0_en  = 1'b1;
            rz1_en  = 1'b1;
            state_d = StRy;
          end else begin
            wait_d  = WaitLoad;
            state_d = StExWait;
          end
        end else if (is_brzr) begin
          alu_ctrl = AluSub;
          if (iZero) begin
            pc_en    = 1'b1;
            mpc_sel  = 1'b1;
            minc_sel = 1'b1;
          end
          retire  = 1'b1;
          state_d = StFetch;
        end else if (is_jr) begin
          pc_en   = 1'b1;
          retire  = 1'b1;
          state_d = StFetch;
        end else if (is_jal) begin
          pc_en   = 1'b1;
          state_d = StRy;
        end else begin
          state_d = StFetch;
        end
      end
      StExWait: begin
        alu_ctrl = alu_md;
        if (wait_q == '0) begin
          rz0_en  = 1'b1;
          rz1_en  = 1'b1;
          state_d = StRy;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      StMem: begin
        mem_read  = is_ld;
        mem_write = is_st;
        if (iDMemReady) begin
          if (is_st) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StRy;
          end
        end
      end
      StRy: begin
        ry_en   = 1'b1;
        my_sel  = is_ld ? 2'd2 : (is_jal ? 2'd3 : 2'd0);
        state_d = StWb;
      end
      StWb: begin
        rf_write = 1'b1;
        mc_sel   = is_jal ? 2'd2 : 2'd0;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: state_d = StFetch;
    endcase

    retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
  end

  // State, wait counter and retire counter registers.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Outputs forced low while reset is asserted, independent of the clock.
  assign oIMemReq  = imem_req & nRst;
  assign oMemRead  = mem_read & nRst;
  assign oMemWrite = mem_write & nRst;
  assign oIrEn     = ir_en & nRst;
  assign oRaEn     = ra_en & nRst;
  assign oRbEn     = rb_en & nRst;
  assign oRz0En    = rz0_en & nRst;
  assign oRz1En    = rz1_en & nRst;
  assign oRmEn     = rm_en & nRst;
  assign oRyEn     = ry_en & nRst;
  assign oPcEn     = pc_en & nRst;
  assign oPcTempEn = pc_temp_en & nRst;
  assign oRfWrite  = rf_write & nRst;
  assign oMbSel    = mb_sel & nRst;
  assign oMincSel  = minc_sel & nRst;
  assign oMpcSel   = mpc_sel & nRst;
  assign oMySel    = nRst ? my_sel : 2'd0;
  assign oMcSel    = nRst ? mc_sel : 2'd0;
  assign oAluCtrl  = nRst ? alu_ctrl : 4'd0;
  assign oHalted   = halted & nRst;
  assign oIllegal  = illegal & nRst;
  assign oRetired  = nRst ? retired_q : '0;

endmodule

// File: tb/tb_minisrc_ctrl_seq.sv
// Directed cycle-by-cycle bench for minisrc_ctrl_seq (MULDIV_CYCLES=4).
// All control outputs are packed into one vector and compared against
// hand-built expected words each cycle.
module tb_minisrc_ctrl_seq;

  localparam int unsigned CntW = 32;

  // Packed output layout, MSB first.
  localparam logic [25:0] BImReq  = 26'd1 << 25;
  localparam logic [25:0] BMemRd  = 26'd1 << 24;
  localparam logic [25:0] BMemWr  = 26'd1 << 23;
  localparam logic [25:0] BIrEn   = 26'd1 << 22;
  localparam logic [25:0] BRaEn   = 26'd1 << 21;
  localparam logic [25:0] BRbEn   = 26'd1 << 20;
  localparam logic [25:0] BRz0En  = 26'd1 << 19;
  localparam logic [25:0] BRz1En  = 26'd1 << 18;
  localparam logic [25:0] BRmEn   = 26'd1 << 17;
  localparam logic [25:0] BRyEn   = 26'd1 << 16;
  localparam logic [25:0] BPcEn   = 26'd1 << 15;
  localparam logic [25:0] BPcTmp  = 26'd1 << 14;
  localparam logic [25:0] BRfWr   = 26'd1 << 13;
  localparam logic [25:0] BMbSel  = 26'd1 << 12;
  localparam logic [25:0] BMinc   = 26'd1 << 11;
  localparam logic [25:0] BMpc    = 26'd1 << 10;
  localparam logic [25:0] BMy2    = 26'd2 << 8;
  localparam logic [25:0] BMy3    = 26'd3 << 8;
  localparam logic [25:0] BMc2    = 26'd2 << 6;
  localparam logic [25:0] BAluSub = 26'd1 << 2;
  localparam logic [25:0] BAluMul = 26'd5 << 2;
  localparam logic [25:0] BHalted = 26'd1 << 1;
  localparam logic [25:0] BIll    = 26'd1;

  localparam logic [25:0] EFetch  = BImReq | BIrEn | BPcTmp | BPcEn | BMpc;
  localparam logic [25:0] EDecode = BRaEn | BRbEn;

  logic            iClk, nRst, iZero, iIMemReady, iDMemReady;
  logic [4:0]      iOpcode;
  logic            oIMemReq, oMemRead, oMemWrite, oIrEn, oRaEn, oRbEn, oRz0En, oRz1En;
  logic            oRmEn, oRyEn, oPcEn, oPcTempEn, oRfWrite, oMbSel, oMincSel, oMpcSel;
  logic [1:0]      oMySel, oMcSel;
  logic [3:0]      oAluCtrl;
  logic            oHalted, oIllegal;
  logic [CntW-1:0] oRetired;
  logic [25:0]     outs;

  int n_checks;
  int n_errors;
  int exp_ret;

  minisrc_ctrl_seq #(
    .MULDIV_CYCLES(4),
    .CNT_W        (CntW)
  ) u_dut (
    .iClk      (iClk),
    .nRst      (nRst),
    .iOpcode   (iOpcode),
    .iZero     (iZero),
    .iIMemReady(iIMemReady),
    .iDMemReady(iDMemReady),
    .oIMemReq  (oIMemReq),
    .oMemRead  (oMemRead),
    .oMemWrite (oMemWrite),
    .oIrEn     (oIrEn),
    .oRaEn     (oRaEn),
    .oRbEn     (oRbEn),
    .oRz0En    (oRz0En),
    .oRz1En    (oRz1En),
    .oRmEn     (oRmEn),
    .oRyEn     (oRyEn),
    .oPcEn     (oPcEn),
    .oPcTempEn (oPcTempEn),
    .oRfWrite  (oRfWrite),
    .oMbSel    (oMbSel),
    .oMincSel  (oMincSel),
    .oMpcSel   (oMpcSel),
    .oMySel    (oMySel),
    .oMcSel    (oMcSel),
    .oAluCtrl  (oAluCtrl),
    .oHalted   (oHalted),
    .oIllegal  (oIllegal),
    .oRetired  (oRetired)
  );

  assign outs = {oIMemReq, oMemRead, oMemWrite, oIrEn, oRaEn, oRbEn, oRz0En, oRz1En,
                 oRmEn, oRyEn, oPcEn, oPcTempEn, oRfWrite, oMbSel, oMincSel, oMpcSel,
                 oMySel, oMcSel, oAluCtrl, oHalted, oIllegal};

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance to just after the next rising edge.
  task automatic run_cycle(input string tag, input logic [25:0] exp);
    #1;
    check(tag, {6'd0, outs}, {6'd0, exp});
    @(posedge iClk);
    #1;
  endtask

  // Instruction finished: FETCH must be reached and the count must match.
  task automatic back_to_fetch(input string tag);
    iIMemReady = 1'b0;
    run_cycle(tag, BImReq);
    check({tag, "_ret"}, oRetired, exp_ret);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    exp_ret    = 0;
    nRst       = 1'b0;
    iOpcode    = 5'b11010;
    iZero      = 1'b0;
    iIMemReady = 1'b0;
    iDMemReady = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    check("rst_outs", {6'd0, outs}, 32'd0);
    check("rst_ret", oRetired, 32'd0);
    nRst = 1'b1;
    run_cycle("fetch_hold0", BImReq);
    run_cycle("fetch_hold1", BImReq);

    // Asynchronous reset in the middle of a stalled fetch.
    nRst = 1'b0;
    #1;
    check("mid_rst_outs", {6'd0, outs}, 32'd0);
    check("mid_rst_ret", oRetired, 32'd0);
    @(posedge iClk);
    #1;
    nRst = 1'b1;
    run_cycle("post_rst_req", BImReq);
    check("post_rst_ret", oRetired, 32'd0);

    // add: 5 cycles.
    iOpcode = 5'b00011; iIMemReady = 1'b1;
    run_cycle("add_fetch", EFetch);
    run_cycle("add_dec", EDecode);
    run_cycle("add_exec", BRz0En);
    run_cycle("add_ry", BRyEn);
    run_cycle("add_wb", BRfWr);
    exp_ret++;
    back_to_fetch("add_done");

    // ld with three data-memory wait cycles: 9 cycles.
    iOpcode = 5'b00000; iIMemReady = 1'b1;
    run_cycle("ld_fetch", EFetch);
    run_cycle("ld_dec", EDecode);
    iDMemReady = 1'b0;
    run_cycle("ld_exec", BRz0En | BMbSel);
    run_cycle("ld_mem0", BMemRd);
    run_cycle("ld_mem1", BMemRd);
    run_cycle("ld_mem2", BMemRd);
    iDMemReady = 1'b1;
    run_cycle("ld_mem3", BMemRd);
    run_cycle("ld_ry", BRyEn | BMy2);
    run_cycle("ld_wb", BRfWr);
    exp_ret++;
    back_to_fetch("ld_done");

    // mul: 8 cycles, multiplier busy 4 of them.
    iOpcode = 5'b01111; iIMemReady = 1'b1;
    run_cycle("mul_fetch", EFetch);
    run_cycle("mul_dec", EDecode);
    run_cycle("mul_ex1", BAluMul);
    run_cycle("mul_ex2", BAluMul);
    run_cycle("mul_ex3", BAluMul);
    run_cycle("mul_ex4", BAluMul | BRz0En | BRz1En);
    run_cycle("mul_ry", BRyEn);
    run_cycle("mul_wb", BRfWr);
    exp_ret++;
    back_to_fetch("mul_done");

    // brzr taken then not taken: 3 cycles each.
    iOpcode = 5'b10010; iZero = 1'b1; iIMemReady = 1'b1;
    run_cycle("brz1_fetch", EFetch);
    run_cycle("brz1_dec", EDecode);
    run_cycle("brz1_exec", BAluSub | BPcEn | BMpc | BMinc);
    exp_ret++;
    check("brz1_ret", oRetired, exp_ret);
    iZero = 1'b0;
    run_cycle("brz0_fetch", EFetch);
    run_cycle("brz0_dec", EDecode);
    run_cycle("brz0_exec", BAluSub);
    exp_ret++;
    back_to_fetch("brz_done");

    // st: 4 cycles.
    iOpcode = 5'b00010; iIMemReady = 1'b1;
    run_cycle("st_fetch", EFetch);
    run_cycle("st_dec", EDecode);
    run_cycle("st_exec", BRz0En | BMbSel | BRmEn);
    run_cycle("st_mem", BMemWr);
    exp_ret++;
    back_to_fetch("st_done");

    // jal: PC from RA, link written via return-address path.
    iOpcode = 5'b10100; iIMemReady = 1'b1;
    run_cycle("jal_fetch", EFetch);
    run_cycle("jal_dec", EDecode);
    run_cycle("jal_exec", BPcEn);
    run_cycle("jal_ry", BRyEn | BMy3);
    run_cycle("jal_wb", BRfWr | BMc2);
    exp_ret++;
    back_to_fetch("jal_done");

    // Illegal opcode: one-cycle pulse, retires as nop.
    iOpcode = 5'b11111; iIMemReady = 1'b1;
    run_cycle("ill_fetch", EFetch);
    run_cycle("ill_dec", EDecode | BIll);
    exp_ret++;
    back_to_fetch("ill_done");

    // halt: parks until reset, no further fetches.
    iOpcode = 5'b11011; iIMemReady = 1'b1;
    run_cycle("halt_fetch", EFetch);
    run_cycle("halt_dec", EDecode);
    for (int i = 0; i < 20; i++) run_cycle("halted", BHalted);
    check("halt_ret", oRetired, exp_ret);

    nRst = 1'b0;
    #1;
    check("halt_rst_outs", {6'd0, outs}, 32'd0);
    check("halt_rst_ret", oRetired, 32'd0);
    @(posedge iClk);
    #1;
    nRst = 1'b1;
    iIMemReady = 1'b0;
    run_cycle("halt_rst_req", BImReq);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
